// File: rtl/sec_fir_mc.sv
// rtl/sec_fir_mc.sv - multichannel time-multiplexed serial FIR with one shared MAC
// Purpose: NCH independent channels, each with a circular delay line of Num_coef
//   samples, filtered by one shared multiply-accumulate against a common,
//   run-time-writable coefficient RAM. One sample is processed at a time.
// Optional feature: define SEC_FIR_SAT_EN to saturate dout instead of wrapping.
// Ports:
//   clk, rst (async, active-low)
//   din/ch_in/val_in  sample input; rdy high when a sample can be taken
//   coef_we/coef_addr/coef_din  coefficient write port, honoured only while rdy
//   dout/ch_out/val_out  filtered sample with its channel, one-cycle strobe
//   ovf  sticky flag, set whenever a sample is dropped
module sec_fir_mc #(
  parameter int Win      = 16,
  parameter int Wc       = 18,
  parameter int Num_coef = 17,
  parameter int NCH      = 2,
  parameter int Wout     = 19,
  parameter int Shift    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Win-1:0]        din,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_in,
  input  logic                  val_in,
  output logic                  rdy,
  input  logic                  coef_we,
  input  logic [$clog2(Num_coef)-1:0] coef_addr,
  input  logic [Wc-1:0]         coef_din,
  output logic [Wout-1:0]       dout,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_out,
  output logic                  val_out,
  output logic                  ovf
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CIW = $clog2(Num_coef);
  localparam int LW  = NCH * Num_coef;
  localparam int LAW = (LW > 1) ? $clog2(LW) : 1;
  localparam int PW  = Win + Wc;
  localparam int AW  = PW + CIW;

  localparam logic [CHW:0]     NCH_W    = (CHW + 1)'(NCH);
  localparam logic [LAW-1:0]   NC_L     = LAW'(Num_coef);
  localparam logic [LAW-1:0]   CLR_LAST = LAW'(LW - 1);
  localparam logic [CIW-1:0]   TAP_LAST = CIW'(Num_coef - 1);
  localparam logic [CIW:0]     NC_C     = (CIW + 1)'(Num_coef);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_DRAIN} state_t;

  // Storage: delay lines laid out channel-major, coefficients shared.
  logic [Win-1:0] dline_mem [LW];
  logic [Wc-1:0]  coef_mem  [Num_coef];

  state_t         state_q, state_d;
  logic [LAW-1:0] clr_q, clr_d;
  logic [CIW-1:0] wptr_q [NCH];
  logic [CIW-1:0] wptr_d [NCH];
  logic [CHW-1:0] ch_q, ch_d;
  logic [CIW-1:0] tap_q, tap_d;
  logic [CIW-1:0] ridx_q, ridx_d;
  logic [1:0]     drn_q, drn_d;
  logic           rdy_q, rdy_d;
  logic           ovf_q, ovf_d;
  logic           val_out_q, val_out_d;
  logic [Wout-1:0] dout_q, dout_d;
  logic [CHW-1:0] ch_out_q, ch_out_d;

  // MAC pipeline: RAM read reg -> operand reg -> product reg -> accumulator.
  logic [Win-1:0] x_rd_q, x_rd_d, x_op_q, x_op_d;
  logic [Wc-1:0]  h_rd_q, h_rd_d, h_op_q, h_op_d;
  logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic           f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [AW-1:0]  acc_q, acc_d;

  logic           dl_we;
  logic [LAW-1:0] dl_waddr;
  logic [Win-1:0] dl_wdata;
  logic [LAW-1:0] rd_addr;
  logic           ch_ok, accept, drop, cf_we;
  logic signed [PW-1:0] x_ext, h_ext;
  logic signed [AW-1:0] prod_ext;
  logic [Wout-1:0] res;

  assign ch_ok   = ({1'b0, ch_in} < NCH_W);
  assign accept  = rdy_q && val_in && ch_ok;
  assign drop    = val_in && !(rdy_q && ch_ok);
  assign cf_we   = coef_we && rdy_q && ({1'b0, coef_addr} < NC_C);
  assign rd_addr = LAW'(ch_q) * NC_L + LAW'(ridx_q);

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    wptr_d    = wptr_q;
    ch_d      = ch_q;
    tap_d     = tap_q;
    ridx_d    = ridx_q;
    drn_d     = drn_q;
    rdy_d     = rdy_q;
    ovf_d     = ovf_q | drop;
    val_out_d = 1'b0;
    dout_d    = dout_q;
    ch_out_d  = ch_out_q;
    dl_we     = 1'b0;
    dl_waddr  = clr_q;
    dl_wdata  = '0;

    v1_d   = 1'b0;
    f1_d   = 1'b0;
    x_rd_d = dline_mem[rd_addr];
    h_rd_d = coef_mem[tap_q];
    x_op_d = x_rd_q;
    h_op_d = h_rd_q;
    v2_d   = v1_q;
    f2_d   = f1_q;
    x_ext  = PW'($signed(x_op_q));
    h_ext  = PW'($signed(h_op_q));
    prod_d = x_ext * h_ext;
    v3_d   = v2_q;
    f3_d   = f2_q;
    prod_ext = AW'($signed(prod_q));
    acc_d  = acc_q;
    if (v3_q) begin
      // The first tap of a sample restarts the sum instead of adding to it.
      acc_d = f3_q ? prod_ext : acc_q + prod_ext;
    end

`ifdef SEC_FIR_SAT_EN
    // Saturate when the bits above the slice are not a sign extension of it.
    if (!acc_q[AW-1] && (|acc_q[AW-1:Shift+Wout-1])) begin
      res = {1'b0, {(Wout-1){1'b1}}};
    end else if (acc_q[AW-1] && !(&acc_q[AW-1:Shift+Wout-1])) begin
      res = {1'b1, {(Wout-1){1'b0}}};
    end else begin
      res = acc_q[Shift+Wout-1:Shift];
    end
`else
    res = acc_q[Shift+Wout-1:Shift];
`endif

    case (state_q)
      S_CLEAR: begin
        dl_we    = 1'b1;
        dl_waddr = clr_q;
        if (clr_q == CLR_LAST) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end else begin
          clr_d = clr_q + LAW'(1);
        end
      end
      S_IDLE: begin
        if (accept) begin
          dl_we    = 1'b1;
          dl_waddr = LAW'(ch_in) * NC_L + LAW'(wptr_q[ch_in]);
          dl_wdata = din;
          ch_d     = ch_in;
          // Tap 0 reads the word just written; later taps walk backwards.
          ridx_d   = wptr_q[ch_in];
          tap_d    = '0;
          wptr_d[ch_in] = (wptr_q[ch_in] == TAP_LAST) ? '0 : wptr_q[ch_in] + CIW'(1);
          state_d  = S_MAC;
          rdy_d    = 1'b0;
        end
      end
      S_MAC: begin
        v1_d   = 1'b1;
        f1_d   = (tap_q == '0);
        ridx_d = (ridx_q == '0) ? TAP_LAST : ridx_q - CIW'(1);
        tap_d  = tap_q + CIW'(1);
        if (tap_q == TAP_LAST) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end
      end
      default: begin
        // Four cycles let the last tap reach the accumulator.
        if (drn_q == 2'd3) begin
          state_d   = S_IDLE;
          rdy_d     = 1'b1;
          val_out_d = 1'b1;
          dout_d    = res;
          ch_out_d  = ch_q;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_q     <= '0;
      for (int i = 0; i < NCH; i++) wptr_q[i] <= '0;
      ch_q      <= '0;
      tap_q     <= '0;
      ridx_q    <= '0;
      drn_q     <= '0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      val_out_q <= 1'b0;
      dout_q    <= '0;
      ch_out_q  <= '0;
      x_rd_q    <= '0;
      h_rd_q    <= '0;
      x_op_q    <= '0;
      h_op_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      f1_q      <= 1'b0;
      f2_q      <= 1'b0;
      f3_q      <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      wptr_q    <= wptr_d;
      ch_q      <= ch_d;
      tap_q     <= tap_d;
      ridx_q    <= ridx_d;
      drn_q     <= drn_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      val_out_q <= val_out_d;
      dout_q    <= dout_d;
      ch_out_q  <= ch_out_d;
      x_rd_q    <= x_rd_d;
      h_rd_q    <= h_rd_d;
      x_op_q    <= x_op_d;
      h_op_q    <= h_op_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      f3_q      <= f3_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
    end
  end

  // RAMs carry no reset: delay lines are zeroed by the CLEAR sweep and the
  // coefficients must survive a reset.
  always_ff @(posedge clk) begin
    if (dl_we) dline_mem[dl_waddr] <= dl_wdata;
    if (cf_we) coef_mem[coef_addr] <= coef_din;
  end

  assign rdy     = rdy_q;
  assign ovf     = ovf_q;
  assign val_out = val_out_q;
  assign dout    = dout_q;
  assign ch_out  = ch_out_q;

endmodule
